sysbus_mem_responder: RTL
=========================

# sysbus_mem_responder

Memory-side responder for the Sysbus request/response protocol driven by the CPU `top` fetch path. It accepts line requests (address plus tag), acknowledges them, and answers reads with an 8-beat, 64-byte line after a programmable latency. With write support compiled in, it also absorbs 8-beat line writes into a local backing store. It is the simulation memory behind the core in standalone benches.

## Interface
- `BUS_DATA_WIDTH`, 64: beat width. Only 64 is supported.
- `BUS_TAG_WIDTH`, 13: tag width.
- `MEM_WORDS`, 4096: backing store depth in 64-bit words. Must be a power of two and at least 8.
- `READ_LATENCY`, 4: idle cycles between the request ack and the first read beat. Legal range is 0..255.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `bus_reqcyc` in 1: request or write-data beat valid.
- `bus_req` in 64: request address, or write data during a write's data phase.
- `bus_reqtag` in 13: request tag. Bit [12] is the memory select (`SYSBUS_MEMORY`). Bits [11:8] are the command (`SYSBUS_READ` / `SYSBUS_WRITE`).
- `bus_reqack` out 1: request or beat accepted.
- `bus_respcyc` out 1: response beat valid.
- `bus_resp` out 64: response data.
- `bus_resptag` out 13: echo of the captured request tag.
- `bus_respack` in 1: initiator consumes the current response beat.

## Operation
- FSM states are IDLE, ACK, WAIT, RESP and WDATA.
- **IDLE**
  - When `bus_reqcyc`=1, capture `bus_req` and `bus_reqtag`. The line base is `bus_req & ~64'h3F`; `bus_req[5:0]` is ignored.
  - Go to ACK.
- **ACK**
  - `bus_reqack`=1 for exactly this cycle.
  - If the tag is a write (command = `SYSBUS_WRITE` and memory select = 1) and writes are enabled, go to WDATA.
  - Otherwise load the latency counter with `READ_LATENCY` and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP in the cycle the counter reads 0. With latency 0, go to RESP directly after ACK.
- **RESP**
  - `bus_respcyc`=1. `bus_resp` = word at index `(base>>3)+beat`, taken modulo `MEM_WORDS`. `bus_resptag` = captured tag.
  - The beat counter (3 bits, starting at 0) advances only in a cycle where `bus_respack`=1. Data and tag stay stable while `bus_respack`=0.
  - After beat 7 is acked, return to IDLE. `bus_respcyc` is low in the following cycle.
- **WDATA**
  - In each cycle with `bus_reqcyc`=1, `bus_reqack`=1 combinationally in the same cycle, and `bus_req` is written to index `(base>>3)+beat`.
  - After beat 7, return to IDLE.
- **Other tags**: a command that is neither read nor write, or memory select = 0, is handled as a read that returns 8 beats of zero.
- `bus_reqcyc` is ignored outside IDLE and WDATA. This includes the ACK cycle, where the initiator may still be holding it high.
- **Reset**
  - Reset forces IDLE and zeroes all counters.
  - All outputs reset to 0: `bus_reqack`, `bus_respcyc`, `bus_resp`, `bus_resptag`.
  - Reset mid-transfer abandons the transaction. Memory contents are not reset; words already written in a partial write stay written.
- **Address wrap**: indices wrap modulo `MEM_WORDS`. A line at the top of memory wraps to word 0.

## Timing
- Request sampled at edge N: `bus_reqack` is high in cycle N+1.
- First read beat is valid in cycle N+2+`READ_LATENCY`.
- Minimum read, with `bus_respack` held at 1: 8 beats in 8 consecutive cycles. Total is 10+`READ_LATENCY` cycles from request to IDLE.
- A new request can be sampled in the first IDLE cycle after the last beat.
- Write-data beats have zero-latency acceptance, one beat per cycle maximum.
- Store reads are combinational from registered indices. Store writes occur at the edge that ends the beat cycle.
- A read of a word written in the preceding write transaction returns the new data.

## Configuration
- `SYSBUS_RESP_WRITE_EN` defined:
  - WDATA state and store write port are present.
  - Writes behave as specified under Operation.
- `SYSBUS_RESP_WRITE_EN` undefined:
  - The write command is treated as an unrecognised command: acked, then a zero-data 8-beat read response is returned.
  - The store is read-only.
  - No write-data phase exists; the initiator must not send data beats.

## Structure
- Shared package `sysbus_pkg` holds:
  - the state enum `sysbus_resp_state_t`;
  - `LINE_BEATS`=8 and `LINE_BYTES`=64;
  - tag-field helper functions `tag_cmd()` and `tag_is_mem()`, built on the existing `SYSBUS_*` defines.
- One sub-module, `sysbus_mem_array`: `MEM_WORDS`×64 storage with one async read port and one sync write port (write port conditional on the macro).

## Test plan
- **Read, latency 4**
  - Stimulus: preload words 0x100..0x107 = 0xA0..0xA7. Send request addr 0x800 with tag `SYSBUS_READ<<8|SYSBUS_MEMORY<<12`.
  - Required: reqack 1 cycle later; first beat 6 cycles after the request; beats 0xA0..0xA7 in order; resptag equals the request tag.
- **Backpressure**
  - Stimulus: deassert respack on beats 2 and 5 for 3 cycles each.
  - Required: data holds for those cycles, no beat is skipped or repeated, and the transfer takes 14 response cycles.
- **Write then read** (macro defined)
  - Stimulus: write line 0x1040 with data 0x11..0x18, with one idle gap between beats 3 and 4. Then read 0x1047.
  - Required: the read returns 0x11..0x18, since the low address bits are ignored.
- **Wrap**
  - Stimulus: with `MEM_WORDS`=4096, read address 0x7FC0.
  - Required: the beats come from indices 0xFF8..0xFFF.
- **Reset mid-response**
  - Stimulus: assert reset on beat 3 of a read.
  - Required: the next cycle shows respcyc=0 and resp=0; the following request is serviced normally.
- **Macro undefined**
  - Stimulus: send a write-tag request.
  - Required: acked, followed by 8 zero beats; memory is unchanged.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared Sysbus responder definitions: tag field defines, FSM state type and tag helpers.
// SYSBUS_RESP_WRITE_EN selects whether the responder accepts line writes.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1'b1
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 4'h1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'h2
`endif

package sysbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_RESP,
        ST_WDATA
    } sysbus_resp_state_t;

    localparam int unsigned LINE_BEATS = 8;
    localparam int unsigned LINE_BYTES = 64;

    function automatic logic [3:0] tag_cmd(input logic [12:0] tag);
        return 4'((tag >> 8) & 13'h00F);
    endfunction

    function automatic logic tag_is_mem(input logic [12:0] tag);
        return 1'(tag >> 12) == `SYSBUS_MEMORY;
    endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing store for the Sysbus responder: asynchronous read port, synchronous write
// port present only when SYSBUS_RESP_WRITE_EN is defined.
module sysbus_mem_array #(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned AW         = $clog2(MEM_WORDS)
) (
`ifdef SYSBUS_RESP_WRITE_EN
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
`endif
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    assign rdata = mem[raddr];

`ifdef SYSBUS_RESP_WRITE_EN
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
`endif

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: acks line requests, returns 8-beat reads after READ_LATENCY.
// SYSBUS_RESP_WRITE_EN adds the 8-beat line write path into the backing store.
module sysbus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);
    import sysbus_pkg::*;

    localparam int unsigned AW = $clog2(MEM_WORDS);

    sysbus_resp_state_t        state;
    logic [AW-1:0]             base_idx;
    logic [AW-1:0]             rd_idx;
    logic [2:0]                beat;
    logic [7:0]                lat;
    logic                      zero_data;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [BUS_DATA_WIDTH-1:0] rd_word;
    logic                      is_read;
    logic                      is_write;
    logic                      unused_addr_bits;

    // Line-aligned base with the beat OR-ed in; truncation to AW bits gives the wrap.
    assign rd_idx  = base_idx | AW'(beat);
    assign is_read = (tag_cmd(tag_q) == `SYSBUS_READ) && tag_is_mem(tag_q);
    assign unused_addr_bits = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[2:0]};

`ifdef SYSBUS_RESP_WRITE_EN
    logic mem_we;

    assign is_write = (tag_cmd(tag_q) == `SYSBUS_WRITE) && tag_is_mem(tag_q);
    assign mem_we   = (state == ST_WDATA) && bus_reqcyc;
`else
    assign is_write = 1'b0;
`endif

    sysbus_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_WIDTH(BUS_DATA_WIDTH)
    ) u_mem (
`ifdef SYSBUS_RESP_WRITE_EN
        .clk  (clk),
        .we   (mem_we),
        .waddr(rd_idx),
        .wdata(bus_req),
`endif
        .raddr(rd_idx),
        .rdata(rd_word)
    );

    always_comb begin
        bus_reqack = (state == ST_ACK);
`ifdef SYSBUS_RESP_WRITE_EN
        if (state == ST_WDATA) begin
            bus_reqack = bus_reqcyc;
        end
`endif
    end

    assign bus_respcyc = (state == ST_RESP);
    assign bus_resp    = (state == ST_RESP && !zero_data) ? rd_word : '0;
    assign bus_resptag = tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_idx  <= '0;
            tag_q     <= '0;
            beat      <= '0;
            lat       <= '0;
            zero_data <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_reqcyc) begin
                        base_idx <= bus_req[AW+2:3] & ~AW'(LINE_BEATS - 1);
                        tag_q    <= bus_reqtag;
                        beat     <= '0;
                        state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    zero_data <= !is_read;
                    if (is_write) begin
                        state <= ST_WDATA;
                    end else if (READ_LATENCY == 0) begin
                        state <= ST_RESP;
                    end else begin
                        lat   <= 8'(READ_LATENCY - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat == '0) begin
                        state <= ST_RESP;
                    end else begin
                        lat <= lat - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (bus_respack) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'(LINE_BEATS - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus_reqcyc) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'(LINE_BEATS - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
